// File: rtl/mio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mio_responder_if
//  Description : CPU-side memory/IO request bus for mio_responder. The master
//                (CPU) drives the request fields; the slave (responder)
//                returns read data, the completion pulse and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mio_responder_if;
    logic        req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MIO_ready;
    logic        busy;

    modport master (
        output req, mem_w, addr, data_in,
        input  data_out, MIO_ready, busy
    );

    modport slave (
        input  req, mem_w, addr, data_in,
        output data_out, MIO_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mio_responder
//  Description : Memory/IO responder with programmable wait states. Serves a
//                word RAM, an LED register, a free-running counter and a
//                switch input port. One transaction at a time; every output
//                is registered and completion is signalled by a one-cycle
//                MIO_ready pulse WAIT_CYCLES+1 cycles after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module mio_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mio_responder_if.slave   bus,
    input  wire logic [15:0] sw,
    output logic      [15:0] led
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam bit         C_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] C_CNT_INIT  = C_ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [31:0] C_ADDR_LED = 32'hF000_0000;
    localparam logic [31:0] C_ADDR_CTR = 32'hF000_0004;
    localparam logic [31:0] C_ADDR_SW  = 32'hE000_0000;

    logic [1:0]  state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        we_q,       we_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        mio_ready_q, mio_ready_d;
    logic        busy_q,     busy_d;
    logic [31:0] data_out_q, data_out_d;
    logic [15:0] led_q,      led_d;
    logic [31:0] ctr_q,      ctr_d;

    logic [31:0] ram_q [2**RAM_AW];

    // Commit-edge qualifiers: with zero wait states the accept edge is also
    // the commit edge, so the live request fields are the captured ones.
    logic              w_commit;
    logic              w_c_we;
    logic [31:0]       w_c_addr;
    logic [31:0]       w_c_wdata;
    logic              w_sel_led;
    logic              w_sel_ctr;
    logic              w_sel_sw;
    logic              w_sel_ram;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_rdata;

    assign w_commit  = C_ZERO_WAIT ? ((state_q == ST_IDLE) && bus.req)
                                   : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign w_c_we    = C_ZERO_WAIT ? bus.mem_w   : we_q;
    assign w_c_addr  = C_ZERO_WAIT ? bus.addr    : addr_q;
    assign w_c_wdata = C_ZERO_WAIT ? bus.data_in : wdata_q;

    assign w_sel_led = (w_c_addr == C_ADDR_LED);
    assign w_sel_ctr = (w_c_addr == C_ADDR_CTR);
    assign w_sel_sw  = (w_c_addr == C_ADDR_SW);
    assign w_sel_ram = (w_c_addr[31:28] != 4'hF) && (w_c_addr[31:28] != 4'hE);
    assign w_ram_idx = w_c_addr[RAM_AW+1:2];

    // Read-data mux over the decoded targets; unmapped space reads as zero.
    always_comb begin
        w_rdata = 32'h0;
        if (w_sel_led) begin
            w_rdata = {16'h0, led_q};
        end else if (w_sel_ctr) begin
            w_rdata = ctr_q;
        end else if (w_sel_sw) begin
            w_rdata = {16'h0, sw};
        end else if (w_sel_ram) begin
            w_rdata = ram_q[w_ram_idx];
        end
    end

    // State register plus the captured request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.mem_w;
                    addr_d  = bus.addr;
                    wdata_d = bus.data_in;
                    if (C_ZERO_WAIT) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/peripheral next values: everything observable changes only at the commit edge,
    // apart from the free-running counter.
    always_comb begin
        mio_ready_d = w_commit;
        busy_d      = (state_d != ST_IDLE);
        data_out_d  = data_out_q;
        led_d       = led_q;
        ctr_d       = ctr_q + 32'd1;
        if (w_commit) begin
            if (w_c_we) begin
                data_out_d = 32'h0;
                if (w_sel_led) begin
                    led_d = w_c_wdata[15:0];
                end
                if (w_sel_ctr) begin
                    ctr_d = w_c_wdata;
                end
            end else begin
                data_out_d = w_rdata;
            end
        end
    end

    // Registered outputs and peripheral registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mio_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            data_out_q  <= 32'h0;
            led_q       <= 16'h0;
            ctr_q       <= 32'h0;
        end else begin
            mio_ready_q <= mio_ready_d;
            busy_q      <= busy_d;
            data_out_q  <= data_out_d;
            led_q       <= led_d;
            ctr_q       <= ctr_d;
        end
    end

    // RAM write port; contents survive reset, but reset still blocks a commit.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_c_we && w_sel_ram) begin
            ram_q[w_ram_idx] <= w_c_wdata;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.MIO_ready = mio_ready_q;
    assign bus.busy      = busy_q;
    assign led           = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mio_responder
//  Description : Directed self-checking bench for mio_responder. One DUT runs
//                with two wait states, a second with zero wait states for the
//                back-to-back streaming case. Expected read data is queued
//                when a request is driven and checked on MIO_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = 16'h0;
    logic [15:0] sw0 = 16'h0;
    logic [15:0] led;
    logic [15:0] led0;
    int          cyc = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb_q[$];

    mio_responder_if bus();
    mio_responder_if bus0();

    mio_responder #(.WAIT_CYCLES(W), .RAM_AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .sw  (sw),
        .led (led)
    );

    mio_responder #(.WAIT_CYCLES(0), .RAM_AW(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0),
        .sw  (sw0),
        .led (led0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one transaction from an idle negedge and returns at the idle negedge
    // after completion. rdy_cyc is the edge count of the commit edge.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input string tag, output int rdy_cyc);
        int k;
        int nbusy;
        bit seen;
        logic [31:0] e;
        sb_q.push_back(exp);
        bus.req     = 1'b1;
        bus.mem_w   = w;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        k = 0; nbusy = 0; seen = 1'b0; rdy_cyc = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy === 1'b1) nbusy++;
            if (bus.MIO_ready === 1'b1) begin
                seen    = 1'b1;
                rdy_cyc = cyc;
            end
            if (k == 1) begin
                bus.mem_w   = ~w;
                bus.addr    = a ^ 32'h0000_0040;
                bus.data_in = ~d;
            end
        end
        e = sb_q.pop_front();
        chk(32'(k), 32'(W + 1), {tag, "_latency"});
        chk(32'(nbusy), 32'(W + 1), {tag, "_busy_cycles"});
        if (seen) chk(bus.data_out, e, {tag, "_data"});
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({31'b0, bus.MIO_ready}, 32'd0, {tag, "_ready_single"});
        chk({31'b0, bus.busy}, 32'd0, {tag, "_idle_busy"});
    endtask

    initial begin
        int rc;
        int cw;
        int n;
        logic [31:0] e;

        bus.req = 1'b0; bus.mem_w = 1'b0; bus.addr = 32'h0; bus.data_in = 32'h0;
        bus0.req = 1'b0; bus0.mem_w = 1'b0; bus0.addr = 32'h0; bus0.data_in = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({31'b0, bus.MIO_ready}, 32'd0, "rst_ready");
        chk({31'b0, bus.busy}, 32'd0, "rst_busy");
        chk(bus.data_out, 32'd0, "rst_data_out");
        chk({16'b0, led}, 32'd0, "rst_led");
        rst = 1'b0;

        // RAM write/read, aliasing, and a background word for the abort test
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "ram_wr", rc);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd", rc);
        chk(bus.data_out, 32'hDEAD_BEEF, "ram_rd_hold");
        run_txn(1'b0, 32'h0000_0410, 32'h0, 32'hDEAD_BEEF, "ram_alias", rc);
        run_txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, "ram_wr20", rc);

        // LED register
        run_txn(1'b1, 32'hF000_0000, 32'h0001_A5A5, 32'h0, "led_wr", rc);
        chk({16'b0, led}, 32'h0000_A5A5, "led_value");
        run_txn(1'b0, 32'hF000_0000, 32'h0, 32'h0000_A5A5, "led_rd", rc);

        // Counter load, then read two transactions later across the wrap
        run_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0, "ctr_wr", cw);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ctr_gap", rc);
        n = cyc;
        e = 32'hFFFF_FFFE + 32'(n + W - cw);
        run_txn(1'b0, 32'hF000_0004, 32'h0, e, "ctr_rd", rc);
        chk({31'b0, (bus.data_out < 32'h0000_1000)}, 32'd1, "ctr_wrapped");

        // Switches and unmapped space
        sw = 16'h1234;
        run_txn(1'b0, 32'hE000_0000, 32'h0, 32'h0000_1234, "sw_rd", rc);
        run_txn(1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 32'h0, "sw_wr", rc);
        run_txn(1'b0, 32'hE000_0000, 32'h0, 32'h0000_1234, "sw_rd2", rc);
        run_txn(1'b0, 32'hF000_0010, 32'h0, 32'h0, "unmapped_rd", rc);

        // Reset during WAIT aborts the write
        bus.req = 1'b1; bus.mem_w = 1'b1; bus.addr = 32'h0000_0020; bus.data_in = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        chk({31'b0, bus.busy}, 32'd1, "abort_busy_before");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({31'b0, bus.MIO_ready}, 32'd0, "abort_ready");
        chk({31'b0, bus.busy}, 32'd0, "abort_busy");
        rst = 1'b0;
        bus.req = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.MIO_ready === 1'b1) n++;
        end
        chk(32'(n), 32'd0, "abort_no_pulse");
        chk({16'b0, led}, 32'd0, "abort_led_cleared");
        run_txn(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, "abort_ram", rc);

        // Zero-wait DUT with req held high: a pulse every other cycle
        @(negedge clk);
        for (int j = 0; j < 13; j++) begin
            if (j > 0) begin
                chk({31'b0, bus0.MIO_ready}, 32'(j % 2), $sformatf("zw_ready_%0d", j));
                if (bus0.MIO_ready === 1'b1 && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk(bus0.data_out, e, $sformatf("zw_data_%0d", j));
                end
            end
            if (j < 12) begin
                sw0 = 16'h0100 + 16'(j);
                bus0.req = 1'b1; bus0.mem_w = 1'b0; bus0.addr = 32'hE000_0000;
                if (j % 2 == 0) sb_q.push_back({16'h0, 16'h0100 + 16'(j)});
                @(negedge clk);
            end
        end
        bus0.req = 1'b0;
        chk(32'(sb_q.size()), 32'd0, "zw_all_served");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-002 Parameter RAM_AW, default 8, RAM word-address width (2^RAM_AW x 32-bit words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  1  CPU memory request, held high until MIO_ready seen.
REQ-006 mem_w  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; addr[1:0] ignored (word access only).
REQ-008 data_in  input  32  write data; sampled with req.
REQ-009 sw  input  16  switch inputs, read-only peripheral.
REQ-010 data_out  output  32  read data, valid while MIO_ready=1.
REQ-011 MIO_ready  output  1  one-cycle completion pulse to the CPU pipeline controller.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 led  output  16  LED register contents.

Function
REQ-014 FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-015 IDLE and req=1 at edge E0: capture mem_w/addr/data_in; go to WAIT with cnt=WAIT_CYCLES-1 (or directly to RESP if WAIT_CYCLES=0).
REQ-016 WAIT: cnt!=0 -> cnt-1, stay; cnt==0 -> RESP at that edge (commit edge).
REQ-017 MIO_ready SHALL be 1 exactly in the cycle after edge E0+WAIT_CYCLES, for exactly one cycle; RESP -> IDLE unconditionally.
REQ-018 Writes and read-data capture occur only at the commit edge, using captured values, never live inputs.
REQ-019 req while state!=IDLE is ignored; changes to mem_w/addr/data_in after E0 have no effect.
REQ-020 req still high in IDLE after RESP starts a new transaction; earliest back-to-back acceptance is E0+WAIT_CYCLES+2.
REQ-021 Decode: addr==0xF000_0000 LED; 0xF000_0004 counter; 0xE000_0000 switches; other addr[31:28]==0xF or 0xE unmapped; everything else RAM at word index addr[RAM_AW+1:2] (upper bits aliased).
REQ-022 RAM: read returns stored word; write stores data_in; read-during-own-write not applicable (one op per transaction).
REQ-023 LED: write loads data_in[15:0]; read returns {16'h0, led}.
REQ-024 Counter: 32-bit free-running, +1 every cycle, wraps 0xFFFF_FFFF -> 0; write loads data_in at commit edge (load wins over increment); read returns value held just before commit edge.
REQ-025 Switches: read returns {16'h0, sw} sampled at commit edge; writes dropped.
REQ-026 Unmapped: reads return 0; writes dropped; MIO_ready still pulses with normal latency.
REQ-027 data_out holds last read value (0 after write transactions) until next commit edge.

Reset
REQ-028 rst=1 at an edge: state IDLE, cnt 0, MIO_ready 0, busy 0, data_out 0, led 0, counter 0; RAM contents not cleared.
REQ-029 rst during WAIT or RESP aborts: no write committed if commit edge not yet reached, no MIO_ready pulse; rst has priority over req.
REQ-030 First request accepted at first edge with rst=0 and req=1.

Verification
REQ-031 WAIT_CYCLES=2: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> MIO_ready exactly 3rd cycle after each accept edge, data_out 0xDEAD_BEEF, busy high 3 cycles per transaction.
REQ-032 Write 0x0001_A5A5 to 0xF000_0000 -> led=0xA5A5; read same address -> data_out 0x0000_A5A5.
REQ-033 Write 0xFFFF_FFFE to 0xF000_0004, read it 2 transactions later -> wrap past 0 observed, value equals elapsed cycles minus 2, mod 2^32.
REQ-034 sw=0x1234, read 0xE000_0000 -> 0x0000_1234; write 0xE000_0000 then read 0xF000_0010 -> 0, MIO_ready pulses normally.
REQ-035 Write 0x5555_5555 to 0x0000_0020, assert rst in WAIT -> no MIO_ready, busy 0 next cycle; later read 0x0000_0020 returns prior contents, not 0x5555_5555.
REQ-036 WAIT_CYCLES=0, req held high continuously -> MIO_ready every other cycle, one transaction per pulse, no missed or duplicated accept.
